// File: rtl/bcd3_sevenseg_scan.sv
// Three-digit multiplexed seven-segment driver for a BCD 000-999 counter.
// Takes one snapshot per frame so the shown digits never tear mid-frame.
module bcd3_sevenseg_scan #(
  parameter int SCAN_DIV   = 16,
  parameter int SEG_ACT_LO = 1,
  parameter int AN_ACT_LO  = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hun,
  input  logic [3:0] ten,
  input  logic [3:0] unit,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_start,
  output logic       err
);

  localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_POL = (SEG_ACT_LO != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0]    AN_POL  = (AN_ACT_LO != 0) ? 3'b111 : 3'b000;
  localparam logic          BLZ     = (BLANK_LZ != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_UNIT = 2'd0,
    S_TEN  = 2'd1,
    S_HUN  = 2'd2
  } state_t;

  // Active-high segment pattern {g,f,e,d,c,b,a}; any non-BCD code shows 'E'.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  logic [CW-1:0] div_cnt_r;
  logic          tick_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          snap_edge_s;
  logic [3:0]    snap_hun_r;
  logic [3:0]    snap_ten_r;
  logic [3:0]    snap_unit_r;
  logic [3:0]    snap_hun_nxt_s;
  logic [3:0]    snap_ten_nxt_s;
  logic [3:0]    snap_unit_nxt_s;
  logic          err_nxt_s;
  logic [3:0]    digit_s;
  logic [2:0]    an_sel_s;
  logic          blank_s;
  logic [6:0]    seg_nxt_s;
  logic [2:0]    an_nxt_s;
  logic [6:0]    seg_r;
  logic [2:0]    an_r;
  logic          frame_start_r;
  logic          err_r;

  assign tick_s = (div_cnt_r == DIV_MAX);

  // Per-digit dwell prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

  // Scan order and snapshot capture at the end of the hundreds slot.
  always_comb begin
    state_nxt_s     = state_r;
    snap_hun_nxt_s  = snap_hun_r;
    snap_ten_nxt_s  = snap_ten_r;
    snap_unit_nxt_s = snap_unit_r;
    err_nxt_s       = err_r;
    snap_edge_s     = 1'b0;
    if (tick_s) begin
      case (state_r)
        S_UNIT:  state_nxt_s = S_TEN;
        S_TEN:   state_nxt_s = S_HUN;
        S_HUN:   state_nxt_s = S_UNIT;
        default: state_nxt_s = S_UNIT;
      endcase
      snap_edge_s = (state_r == S_HUN);
    end else begin
      state_nxt_s = state_r;
    end
    if (snap_edge_s) begin
      snap_hun_nxt_s  = hun;
      snap_ten_nxt_s  = ten;
      snap_unit_nxt_s = unit;
      err_nxt_s       = (hun > 4'd9) || (ten > 4'd9) || (unit > 4'd9);
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Display for the slot being entered, built from the snapshot it will see.
  always_comb begin
    digit_s  = snap_unit_nxt_s;
    an_sel_s = 3'b001;
    blank_s  = 1'b0;
    case (state_nxt_s)
      S_UNIT: begin
        digit_s  = snap_unit_nxt_s;
        an_sel_s = 3'b001;
        blank_s  = 1'b0;
      end
      S_TEN: begin
        digit_s  = snap_ten_nxt_s;
        an_sel_s = 3'b010;
        blank_s  = BLZ && (snap_hun_nxt_s == 4'd0) && (snap_ten_nxt_s == 4'd0);
      end
      S_HUN: begin
        digit_s  = snap_hun_nxt_s;
        an_sel_s = 3'b100;
        blank_s  = BLZ && (snap_hun_nxt_s == 4'd0);
      end
      default: begin
        digit_s  = snap_unit_nxt_s;
        an_sel_s = 3'b001;
        blank_s  = 1'b0;
      end
    endcase
    if (blank_s) begin
      seg_nxt_s = SEG_POL;
      an_nxt_s  = AN_POL;
    end else begin
      seg_nxt_s = bcd_to_seg(digit_s) ^ SEG_POL;
      an_nxt_s  = an_sel_s ^ AN_POL;
    end
  end

  // State, snapshot and registered board outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_UNIT;
      snap_hun_r    <= 4'd0;
      snap_ten_r    <= 4'd0;
      snap_unit_r   <= 4'd0;
      err_r         <= 1'b0;
      frame_start_r <= 1'b0;
      seg_r         <= 7'h3F ^ SEG_POL;
      an_r          <= 3'b001 ^ AN_POL;
    end else begin
      state_r       <= state_nxt_s;
      snap_hun_r    <= snap_hun_nxt_s;
      snap_ten_r    <= snap_ten_nxt_s;
      snap_unit_r   <= snap_unit_nxt_s;
      err_r         <= err_nxt_s;
      frame_start_r <= snap_edge_s;
      seg_r         <= seg_nxt_s;
      an_r          <= an_nxt_s;
    end
  end

  assign seg         = seg_r;
  assign an          = an_r;
  assign frame_start = frame_start_r;
  assign err         = err_r;

endmodule

// File: tb/tb_bcd3_sevenseg_scan.sv
// Bench for bcd3_sevenseg_scan: vector table, corner sequences and a
// frame-level reference model checked every cycle on two configurations.
module tb_bcd3_sevenseg_scan;

  localparam int DIV = 4;
  localparam int FRAME = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hun = 4'd1, ten = 4'd2, unit = 4'd3;
  logic [6:0] seg1, seg2;
  logic [2:0] an1, an2;
  logic       fs1, fs2, err1, err2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bcd3_sevenseg_scan #(.SCAN_DIV(DIV), .SEG_ACT_LO(1), .AN_ACT_LO(1), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .hun(hun), .ten(ten), .unit(unit),
    .seg(seg1), .an(an1), .frame_start(fs1), .err(err1));

  bcd3_sevenseg_scan #(.SCAN_DIV(DIV), .SEG_ACT_LO(0), .AN_ACT_LO(0), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .hun(hun), .ten(ten), .unit(unit),
    .seg(seg2), .an(an2), .frame_start(fs2), .err(err2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset, latest snapshot taken once per frame.
  logic [6:0] seg_tab [16];
  int         m_k;
  logic [3:0] m_h, m_t, m_u;
  logic       m_err, m_fs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_h <= 4'd0; m_t <= 4'd0; m_u <= 4'd0; m_err <= 1'b0; m_fs <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if ((m_k + 1) % FRAME == 0) begin
        m_h <= hun; m_t <= ten; m_u <= unit;
        m_err <= (hun > 4'd9) || (ten > 4'd9) || (unit > 4'd9);
        m_fs <= 1'b1;
      end else begin
        m_fs <= 1'b0;
      end
    end
  end

  // Slot index 0=unit,1=ten,2=hun; leading zeros stripped down to one digit.
  function automatic logic [9:0] model_disp(input int k, input logic [3:0] h, t, u,
                                            input bit blz, slo, alo);
    int slot, nvis;
    logic [3:0] d;
    logic [6:0] s;
    logic [2:0] a;
    slot = (k / DIV) % 3;
    d = (slot == 0) ? u : (slot == 1) ? t : h;
    nvis = (h != 4'd0) ? 3 : (t != 4'd0) ? 2 : 1;
    if (!blz || slot < nvis) begin
      s = seg_tab[d];
      a = 3'b001 << slot;
    end else begin
      s = 7'h00;
      a = 3'b000;
    end
    if (slo) s = ~s;
    if (alo) a = ~a;
    return {s, a};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [9:0] e1, e2;
      e1 = model_disp(m_k, m_h, m_t, m_u, 1'b1, 1'b1, 1'b1);
      e2 = model_disp(m_k, m_h, m_t, m_u, 1'b0, 1'b0, 1'b0);
      chk("mon_seg1", {25'd0, seg1}, {25'd0, e1[9:3]});
      chk("mon_an1", {29'd0, an1}, {29'd0, e1[2:0]});
      chk("mon_fs1", {31'd0, fs1}, {31'd0, m_fs});
      chk("mon_err1", {31'd0, err1}, {31'd0, m_err});
      chk("mon_seg2", {25'd0, seg2}, {25'd0, e2[9:3]});
      chk("mon_an2", {29'd0, an2}, {29'd0, e2[2:0]});
      chk("mon_fs2", {31'd0, fs2}, {31'd0, m_fs});
    end
  end

  typedef struct {
    logic [3:0] h, t, u;
    logic [6:0] seg_u, seg_t, seg_h;
    logic [2:0] an_u, an_t, an_h;
    logic       err;
    logic [6:0] seg2_h;
  } vec_t;

  vec_t vecs [7];

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs1 !== 1'b1 && n < 40);
    if (fs1 !== 1'b1) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input int i);
    logic [6:0] es;
    logic [2:0] ea;
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      case (j / DIV)
        0:       begin es = vecs[i].seg_u; ea = vecs[i].an_u; end
        1:       begin es = vecs[i].seg_t; ea = vecs[i].an_t; end
        default: begin es = vecs[i].seg_h; ea = vecs[i].an_h; end
      endcase
      chk("vec_seg", {25'd0, seg1}, {25'd0, es});
      chk("vec_an", {29'd0, an1}, {29'd0, ea});
      chk("vec_fs", {31'd0, fs1}, (j == 0) ? 32'd1 : 32'd0);
      chk("vec_err", {31'd0, err1}, {31'd0, vecs[i].err});
      if (j / DIV == 2) begin
        chk("vec_nb_seg_h", {25'd0, seg2}, {25'd0, vecs[i].seg2_h});
        chk("vec_nb_an_h", {29'd0, an2}, 32'd4);
      end
    end
  endtask

  function automatic logic [3:0] rnd_digit();
    int r;
    r = $urandom_range(0, 19);
    if (r < 4) return 4'd0;
    else if (r < 17) return 4'(r % 10);
    else return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    int n;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    //           h      t      u      seg_u  seg_t  seg_h  an_u    an_t    an_h    err   seg2_h
    vecs[0] = '{4'd1,  4'd2,  4'd3,  7'h30, 7'h24, 7'h79, 3'b110, 3'b101, 3'b011, 1'b0, 7'h06};
    vecs[1] = '{4'd0,  4'd0,  4'd7,  7'h78, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111, 1'b0, 7'h3F};
    vecs[2] = '{4'd0,  4'd0,  4'd0,  7'h40, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111, 1'b0, 7'h3F};
    vecs[3] = '{4'd0,  4'd5,  4'd0,  7'h40, 7'h12, 7'h7F, 3'b110, 3'b101, 3'b111, 1'b0, 7'h3F};
    vecs[4] = '{4'd0,  4'hC,  4'd1,  7'h79, 7'h06, 7'h7F, 3'b110, 3'b101, 3'b111, 1'b1, 7'h3F};
    vecs[5] = '{4'd9,  4'd8,  4'd4,  7'h19, 7'h00, 7'h10, 3'b110, 3'b101, 3'b011, 1'b0, 7'h6F};
    vecs[6] = '{4'hA,  4'd0,  4'd0,  7'h40, 7'h40, 7'h06, 3'b110, 3'b101, 3'b011, 1'b1, 7'h79};

    #1 rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", {29'd0, an1}, 32'h6);
    chk("rst_seg", {25'd0, seg1}, 32'h40);
    chk("rst_fs", {31'd0, fs1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_nb_an", {29'd0, an2}, 32'h1);
    chk("rst_nb_seg", {25'd0, seg2}, 32'h3F);

    #2 rst = 1'b0;
    wait_fs(n);
    chk("first_fs_latency", n, FRAME);

    for (int i = 0; i < 7; i++) begin
      hun = vecs[i].h; ten = vecs[i].t; unit = vecs[i].u;
      wait_fs(n);
      check_frame(i);
    end

    // Inputs changing mid-frame must not reach the remaining slots.
    hun = 4'd1; ten = 4'd2; unit = 4'd3;
    wait_fs(n);
    repeat (DIV) @(negedge clk);
    hun = 4'd4; ten = 4'd5; unit = 4'd6;
    chk("tear_ten_seg", {25'd0, seg1}, 32'h24);
    repeat (DIV) @(negedge clk);
    chk("tear_hun_seg", {25'd0, seg1}, 32'h79);
    wait_fs(n);
    chk("tear_new_unit", {25'd0, seg1}, 32'h02);

    // Reset in the middle of the tens slot.
    repeat (DIV + 1) @(negedge clk);
    chk("mid_ten_an", {29'd0, an1}, 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", {29'd0, an1}, 32'h6);
    chk("midrst_seg", {25'd0, seg1}, 32'h40);
    chk("midrst_fs", {31'd0, fs1}, 32'd0);
    chk("midrst_err", {31'd0, err1}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_fs(n);
    chk("refs_latency", n, FRAME);
    chk("refs_unit", {25'd0, seg1}, 32'h02);

    // Random traffic with occasional resets, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        hun = rnd_digit(); ten = rnd_digit(); unit = rnd_digit();
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
